pe_bus_arbiter: RTL and testbench

PE_BUS_ARBITER -- requirements
Module: pe_bus_arbiter

---
 rtl/pe_bus_arbiter.sv | 119 +++++++++++
 tb/tb_pe_bus_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_bus_arbiter.sv
// Round-robin arbiter for a shared PE broadcast bus: one grant per cycle, and the
// granted word is delivered to its one-hot destination one cycle later.
module pe_bus_arbiter #(
   parameter int unsigned logNumPe      = 3,
   parameter int unsigned dataLen       = 16,
   parameter int unsigned peBusIndexLen = logNumPe + 1
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [(1 << logNumPe)*dataLen-1:0]       pe_bus_data_out,
   input  logic [(1 << logNumPe)*peBusIndexLen-1:0] pe_bus_data_out_v,
   output logic [(1 << logNumPe)-1:0]               pe_bus_contention,
   output logic [dataLen-1:0]                       pe_bus_data_in,
   output logic [(1 << logNumPe)-1:0]               pe_bus_data_in_v,
   output logic [15:0]                              xfer_count,
   output logic                                     dest_err
);

   localparam int unsigned NUM_PE = 1 << logNumPe;
   localparam int unsigned CNT_W  = 16;
   localparam logic [peBusIndexLen-1:0] MAX_IDX = peBusIndexLen'(NUM_PE);

   logic [NUM_PE-1:0]        req;
   logic [NUM_PE-1:0]        grant;
   logic                     gnt_any;
   logic [logNumPe-1:0]      gnt_idx;
   logic [logNumPe-1:0]      scan_idx;
   logic [dataLen-1:0]       sel_data;
   logic [peBusIndexLen-1:0] sel_idx;
   logic                     dst_valid;
   logic                     dst_bad;

   logic [logNumPe-1:0]      rr_ptr_q, rr_ptr_d;
   logic [dataLen-1:0]       data_in_q, data_in_d;
   logic [NUM_PE-1:0]        data_in_v_q, data_in_v_d;
   logic [CNT_W-1:0]         xfer_count_q, xfer_count_d;
   logic                     dest_err_q, dest_err_d;

   // A PE requests whenever its destination index is nonzero.
   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < NUM_PE; i++) begin
         req[i] = |pe_bus_data_out_v[i*peBusIndexLen +: peBusIndexLen];
      end
   end

   // First requester at or above rr_ptr, wrapping through the top PE.
   always_comb begin
      grant    = '0;
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      for (int unsigned off = 0; off < NUM_PE; off++) begin
         scan_idx = rr_ptr_q + logNumPe'(off);
         if (!gnt_any && req[scan_idx]) begin
            gnt_any         = 1'b1;
            gnt_idx         = scan_idx;
            grant[scan_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      sel_idx  = '0;
      for (int unsigned i = 0; i < NUM_PE; i++) begin
         if (grant[i]) begin
            sel_data = pe_bus_data_out[i*dataLen +: dataLen];
            sel_idx  = pe_bus_data_out_v[i*peBusIndexLen +: peBusIndexLen];
         end
      end
   end

   assign dst_bad           = gnt_any && (sel_idx > MAX_IDX);
   assign dst_valid         = gnt_any && !dst_bad;
   assign pe_bus_contention = req & ~grant;

   // Next-state for pointer, delivery registers, counter and sticky error.
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      data_in_d    = data_in_q;
      data_in_v_d  = '0;
      xfer_count_d = xfer_count_q;
      dest_err_d   = dest_err_q;
      if (gnt_any) begin
         rr_ptr_d = gnt_idx + logNumPe'(1);
      end
      if (dst_valid) begin
         data_in_d    = sel_data;
         data_in_v_d[logNumPe'(sel_idx - peBusIndexLen'(1))] = 1'b1;
         xfer_count_d = xfer_count_q + CNT_W'(1);
      end
      if (dst_bad) begin
         dest_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         data_in_q    <= '0;
         data_in_v_q  <= '0;
         xfer_count_q <= '0;
         dest_err_q   <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         data_in_q    <= data_in_d;
         data_in_v_q  <= data_in_v_d;
         xfer_count_q <= xfer_count_d;
         dest_err_q   <= dest_err_d;
      end
   end

   assign pe_bus_data_in   = data_in_q;
   assign pe_bus_data_in_v = data_in_v_q;
   assign xfer_count       = xfer_count_q;
   assign dest_err         = dest_err_q;

endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Scoreboard bench for pe_bus_arbiter: a behavioural model predicts contention and
// next-cycle bus outputs; a monitor pops predictions and compares each cycle.
module tb_pe_bus_arbiter;

   localparam int N  = 8;
   localparam int DW = 16;
   localparam int IW = 4;

   typedef struct {
      logic [N-1:0]  v;
      logic [DW-1:0] d;
      logic [15:0]   cnt;
      logic          err;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [N*DW-1:0]   pe_bus_data_out;
   logic [N*IW-1:0]   pe_bus_data_out_v;
   logic [N-1:0]      pe_bus_contention;
   logic [DW-1:0]     pe_bus_data_in;
   logic [N-1:0]      pe_bus_data_in_v;
   logic [15:0]       xfer_count;
   logic              dest_err;

   pe_bus_arbiter #(.logNumPe(3), .dataLen(DW), .peBusIndexLen(IW)) dut (
      .clk              (clk),
      .reset            (reset),
      .pe_bus_data_out  (pe_bus_data_out),
      .pe_bus_data_out_v(pe_bus_data_out_v),
      .pe_bus_contention(pe_bus_contention),
      .pe_bus_data_in   (pe_bus_data_in),
      .pe_bus_data_in_v (pe_bus_data_in_v),
      .xfer_count       (xfer_count),
      .dest_err         (dest_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   exp_t sb[$];
   exp_t mon_e;

   logic [DW-1:0] drv_data[N];
   logic [IW-1:0] drv_idx[N];

   // Reference state: pointer, held data word, delivery count and sticky error.
   int            m_ptr  = 0;
   logic [DW-1:0] m_data = '0;
   int            m_cnt  = 0;
   logic          m_err  = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic clear_drv();
      for (int i = 0; i < N; i++) begin
         drv_data[i] = 16'($urandom);
         drv_idx[i]  = '0;
      end
   endtask

   // Drive one cycle of stimulus, check contention, push the predicted outputs.
   task automatic step(input logic rst, output int g);
      logic [N-1:0] exp_cont;
      exp_t         e;
      @(negedge clk);
      reset = rst;
      for (int i = 0; i < N; i++) begin
         pe_bus_data_out[i*DW +: DW]   = drv_data[i];
         pe_bus_data_out_v[i*IW +: IW] = drv_idx[i];
      end
      #1;
      g = -1;
      for (int s = 0; s < N; s++) begin
         int p;
         p = (m_ptr + s) % N;
         if (g < 0 && drv_idx[p] != 0) g = p;
      end
      exp_cont = '0;
      for (int i = 0; i < N; i++) begin
         if (drv_idx[i] != 0 && i != g) exp_cont[i] = 1'b1;
      end
      chk("contention", 32'(pe_bus_contention), 32'(exp_cont));
      e.v = '0;
      if (rst) begin
         m_ptr  = 0;
         m_data = '0;
         m_cnt  = 0;
         m_err  = 1'b0;
      end else if (g >= 0) begin
         m_ptr = (g + 1) % N;
         if (int'(drv_idx[g]) > N) begin
            m_err = 1'b1;
         end else begin
            e.v[int'(drv_idx[g]) - 1] = 1'b1;
            m_data = drv_data[g];
            m_cnt  = (m_cnt + 1) % 65536;
         end
      end
      e.d   = m_data;
      e.cnt = 16'(m_cnt);
      e.err = m_err;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("data_in_v",  32'(pe_bus_data_in_v), 32'(mon_e.v));
         chk("data_in",    32'(pe_bus_data_in),   32'(mon_e.d));
         chk("xfer_count", 32'(xfer_count),       32'(mon_e.cnt));
         chk("dest_err",   32'(dest_err),         32'(mon_e.err));
      end
   end

   initial begin
      int           g;
      logic [N-1:0] pending;
      reset             = 1'b1;
      pe_bus_data_out   = '0;
      pe_bus_data_out_v = '0;
      clear_drv();
      step(1'b1, g);
      step(1'b1, g);

      // Single request from PE 2 to PE 5.
      clear_drv();
      drv_data[2] = 16'h1234;
      drv_idx[2]  = 4'd6;
      step(1'b0, g);
      @(posedge clk); #2;
      chk("single_data", 32'(pe_bus_data_in),   32'h1234);
      chk("single_v",    32'(pe_bus_data_in_v), 32'h20);
      chk("single_cnt",  32'(xfer_count),       32'd1);
      clear_drv();
      step(1'b0, g);

      // All PEs request and hold until granted.
      pending = '1;
      for (int c = 0; c < N; c++) begin
         for (int i = 0; i < N; i++) drv_idx[i] = pending[i] ? 4'd1 : 4'd0;
         step(1'b0, g);
         if (g >= 0) pending[g] = 1'b0;
      end
      clear_drv();
      step(1'b0, g);
      @(posedge clk); #2;
      chk("fair_cnt", 32'(xfer_count), 32'd9);

      // Move pointer to 6, then PEs 1 and 7 together: 7 first, then 1.
      clear_drv();
      drv_idx[5] = 4'd3;
      step(1'b0, g);
      clear_drv();
      drv_idx[1] = 4'd2;
      drv_idx[7] = 4'd4;
      step(1'b0, g);
      drv_idx[7] = 4'd0;
      step(1'b0, g);
      @(posedge clk); #2;
      chk("wrap_second_v", 32'(pe_bus_data_in_v), 32'h02);
      clear_drv();
      step(1'b0, g);

      // Invalid destination, then valid traffic.
      drv_idx[0] = 4'd12;
      step(1'b0, g);
      @(posedge clk); #2;
      chk("bad_v",   32'(pe_bus_data_in_v), 32'h0);
      chk("bad_err", 32'(dest_err),         32'd1);
      clear_drv();
      drv_idx[4] = 4'd8;
      step(1'b0, g);
      clear_drv();
      step(1'b0, g);
      @(posedge clk); #2;
      chk("err_sticky", 32'(dest_err), 32'd1);

      // Randomized traffic, including invalid and self destinations.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            drv_data[i] = 16'($urandom);
            drv_idx[i]  = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(1, 10)) : 4'd0;
         end
         step(1'b0, g);
      end

      // Drive the counter round to 0xFFFF, then one more delivery wraps it.
      begin
         int n;
         n = 65536 - m_cnt;
         repeat (n) begin
            int p;
            clear_drv();
            p = int'($urandom_range(0, N - 1));
            drv_idx[p] = 4'($urandom_range(1, N));
            step(1'b0, g);
         end
      end
      @(posedge clk); #2;
      chk("cnt_wrap", 32'(xfer_count), 32'd0);

      // Reset asserted while a grant is being made.
      clear_drv();
      drv_idx[3] = 4'd4;
      step(1'b1, g);
      @(posedge clk); #2;
      chk("rst_v",   32'(pe_bus_data_in_v), 32'h0);
      chk("rst_cnt", 32'(xfer_count),       32'd0);
      chk("rst_err", 32'(dest_err),         32'd0);
      clear_drv();
      drv_idx[0] = 4'd2;
      drv_idx[3] = 4'd7;
      step(1'b0, g);
      @(posedge clk); #2;
      chk("rst_ptr0_v", 32'(pe_bus_data_in_v), 32'h02);
      clear_drv();
      step(1'b0, g);
      step(1'b0, g);

      repeat (2) @(posedge clk);
      #3;
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
